// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide controller.
package hilo_muldiv_ctrl_pkg;

  localparam int unsigned MD_XLEN  = 32;
  localparam int unsigned MD_ITERS = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StFix    = 2'd2,
    StCommit = 2'd3
  } md_state_t;

  function automatic logic md_is_div(md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  // Two's-complement negate when neg is set; 32'h8000_0000 maps to itself,
  // which is also its correct unsigned magnitude.
  function automatic logic [MD_XLEN-1:0] md_abs(logic [MD_XLEN-1:0] v, logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_iter.sv
// muldiv_iter datapath: 64-bit accumulator / partial remainder with load, step and sign fix.
// Multiply: acc = {partial product, multiplier}, shift-add one bit per step.
// Divide:   acc = {remainder, dividend/quotient}, restoring divide one bit per step.
// HILO_FAST_MUL_EN: a multiply step computes the whole 32x32 product at once.
module hilo_muldiv_ctrl_iter
  import hilo_muldiv_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic                 step,
  input  logic                 fix,
  input  logic                 is_div,
  input  logic [MD_XLEN-1:0]   opa,
  input  logic [MD_XLEN-1:0]   opb,
  input  logic                 neg_prod,
  input  logic                 neg_q,
  input  logic                 neg_r,
  output logic [2*MD_XLEN-1:0] acc
);

  logic [2*MD_XLEN-1:0] acc_q, acc_d;
  logic [MD_XLEN-1:0]   opd_q, opd_d;
  logic [MD_XLEN:0]     rem_shift, rem_diff;
`ifndef HILO_FAST_MUL_EN
  logic [MD_XLEN:0]     add_sum;
`endif

  // Next accumulator: load operands, one radix-2 step, or apply result signs
  always_comb begin
    acc_d     = acc_q;
    opd_d     = opd_q;
    rem_shift = acc_q[2*MD_XLEN-1:MD_XLEN-1];
    rem_diff  = rem_shift - {1'b0, opd_q};
`ifndef HILO_FAST_MUL_EN
    add_sum   = {1'b0, acc_q[2*MD_XLEN-1:MD_XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
`endif
    if (load) begin
      opd_d = is_div ? opb : opa;
      acc_d = {{MD_XLEN{1'b0}}, (is_div ? opa : opb)};
    end else if (step) begin
      if (is_div) begin
        // Borrow out of the 33-bit subtract means the divisor did not fit
        acc_d = rem_diff[MD_XLEN] ? {rem_shift[MD_XLEN-1:0], acc_q[MD_XLEN-2:0], 1'b0}
                                  : {rem_diff[MD_XLEN-1:0], acc_q[MD_XLEN-2:0], 1'b1};
      end else begin
`ifdef HILO_FAST_MUL_EN
        acc_d = {{MD_XLEN{1'b0}}, opd_q} * {{MD_XLEN{1'b0}}, acc_q[MD_XLEN-1:0]};
`else
        acc_d = {add_sum, acc_q[MD_XLEN-1:1]};
`endif
      end
    end else if (fix) begin
      if (is_div) begin
        acc_d[2*MD_XLEN-1:MD_XLEN] = md_abs(acc_q[2*MD_XLEN-1:MD_XLEN], neg_r);
        acc_d[MD_XLEN-1:0]         = md_abs(acc_q[MD_XLEN-1:0], neg_q);
      end else if (neg_prod) begin
        acc_d = ~acc_q + 1'b1;
      end
    end
  end

  // Accumulator and stored addend/divisor
  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_q <= '0;
      opd_q <= '0;
    end else begin
      acc_q <= acc_d;
      opd_q <= opd_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: sequences MULT/MULTU/DIV/DIVU, arbitrates HI/LO writes, forwards HI/LO.
// Optional HILO_FAST_MUL_EN: single-cycle multiply in RUN (divide stays iterative).
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned ITER_BITS = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  input  md_op_t             req_op,
  input  logic [MD_XLEN-1:0] req_a,
  input  logic [MD_XLEN-1:0] req_b,
  output logic               req_ready,
  input  logic               flush,
  input  logic               hi_write,
  input  logic               lo_write,
  input  logic [MD_XLEN-1:0] hi_data,
  input  logic [MD_XLEN-1:0] lo_data,
  output logic [MD_XLEN-1:0] hi_rdata,
  output logic [MD_XLEN-1:0] lo_rdata,
  output logic               busy,
  output logic               done
);

  md_state_t            state_q, state_d;
  logic [ITER_BITS-1:0] cnt_q, cnt_d;
  logic [MD_XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  md_op_t               op_q, op_d;
  logic                 sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;

  logic                 accept, step, fix, commit_en, req_signed, iter_div;
  logic [2*MD_XLEN-1:0] acc;

  assign accept     = req_valid & req_ready;
  assign req_signed = md_is_signed(req_op);
  assign iter_div   = accept ? md_is_div(req_op) : md_is_div(op_q);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic; flush wins from any state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StRun;
      StRun:    if (cnt_q == '0) state_d = StFix;
      StFix:    state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // FSM outputs and datapath controls
  always_comb begin
    req_ready = (state_q == StIdle) & ~flush;
    busy      = (state_q != StIdle);
    done      = (state_q == StCommit);
    step      = (state_q == StRun);
    fix       = (state_q == StFix);
    commit_en = (state_q == StCommit) & ~flush;
  end

  // Operation context, iteration counter and HI/LO next values
  always_comb begin
    op_d  = op_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    dz_d  = dz_q;
    cnt_d = cnt_q;
    if (accept) begin
      op_d = req_op;
      sa_d = req_signed & req_a[MD_XLEN-1];
      sb_d = req_signed & req_b[MD_XLEN-1];
      dz_d = (req_b == '0);
`ifdef HILO_FAST_MUL_EN
      cnt_d = md_is_div(req_op) ? ITER_BITS'(MD_ITERS - 1) : '0;
`else
      cnt_d = ITER_BITS'(MD_ITERS - 1);
`endif
    end else if (step && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    // Write-back MTHI/MTLO takes priority per half over a commit
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit_en) begin
      hi_d = acc[2*MD_XLEN-1:MD_XLEN];
      lo_d = acc[MD_XLEN-1:0];
    end
    if (hi_write) hi_d = hi_data;
    if (lo_write) lo_d = lo_data;
  end

  // Context and architectural HI/LO registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      op_q  <= MD_MULT;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      dz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      op_q  <= op_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      dz_q  <= dz_d;
    end
  end

  // Forwarded read data is exactly the value HI/LO will hold after this edge
  assign hi_rdata = hi_d;
  assign lo_rdata = lo_d;

  hilo_muldiv_ctrl_iter u_iter (
    .clk      (clk),
    .resetn   (resetn),
    .load     (accept),
    .step     (step),
    .fix      (fix),
    .is_div   (iter_div),
    .opa      (md_abs(req_a, req_signed & req_a[MD_XLEN-1])),
    .opb      (md_abs(req_b, req_signed & req_b[MD_XLEN-1])),
    .neg_prod (sa_q ^ sb_q),
    // Divide by zero keeps the all-ones quotient unsigned-looking
    .neg_q    ((sa_q ^ sb_q) & ~dz_q),
    .neg_r    (sa_q),
    .acc      (acc)
  );

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

`ifdef HILO_FAST_MUL_EN
  localparam int MulLat = 3;
`else
  localparam int MulLat = 34;
`endif
  localparam int DivLat = 34;

  logic        clk = 1'b0;
  logic        resetn, req_valid, req_ready, flush, hi_write, lo_write, busy, done;
  md_op_t      req_op;
  logic [31:0] req_a, req_b, hi_data, lo_data, hi_rdata, lo_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(.ITER_BITS(6)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .flush     (flush),
    .hi_write  (hi_write),
    .lo_write  (lo_write),
    .hi_data   (hi_data),
    .lo_data   (lo_data),
    .hi_rdata  (hi_rdata),
    .lo_rdata  (lo_rdata),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, return in the cycle after the accept edge (cycle T0+1)
  task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    #1;
    check_eq({tag, " ready"}, 64'(req_ready), 64'd1);
    next_cycle();
    req_valid = 1'b0;
    #1;
    check_eq({tag, " busy T0+1"}, 64'(busy), 64'd1);
  endtask

  // Wait for done from cycle T0+1; returns the cycle index (T0+n) it was seen in
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 200) begin
      next_cycle();
      n++;
    end
  endtask

  task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int lat, input string tag);
    int n;
    issue(op, a, b, tag);
    wait_done(n);
    check_eq({tag, " latency"}, 64'(n), 64'(lat));
    check_eq({tag, " busy@done"}, 64'(busy), 64'd1);
    check_eq({tag, " fwd hi"}, 64'(hi_rdata), 64'(exp_hi));
    check_eq({tag, " fwd lo"}, 64'(lo_rdata), 64'(exp_lo));
    next_cycle();
    check_eq({tag, " idle"}, {62'd0, busy, done}, 64'd0);
    check_eq({tag, " hi"}, 64'(hi_rdata), 64'(exp_hi));
    check_eq({tag, " lo"}, 64'(lo_rdata), 64'(exp_lo));
  endtask

  initial begin
    int n;
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_op    = MD_MULT;
    req_a     = '0;
    req_b     = '0;
    flush     = 1'b0;
    hi_write  = 1'b0;
    lo_write  = 1'b0;
    hi_data   = '0;
    lo_data   = '0;
    repeat (2) next_cycle();
    check_eq("reset ready", 64'(req_ready), 64'd1);
    check_eq("reset busy/done", {62'd0, busy, done}, 64'd0);
    check_eq("reset hilo", {hi_rdata, lo_rdata}, 64'd0);
    resetn = 1'b1;
    next_cycle();

    // Signed / unsigned multiply and divide
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MulLat, "mult -3*7");
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MulLat,
           "multu max");
    run_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DivLat, "divu 100/7");
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DivLat, "div -7/2");
    run_op(MD_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, DivLat, "divu big");
    run_op(MD_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DivLat, "div 5/0");
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DivLat, "div ovf");

    // Flush in cycle T0+10 of a divide: HI/LO keep the overflow result
    issue(MD_DIVU, 32'd50, 32'd3, "flush divu");
    repeat (9) next_cycle();
    flush = 1'b1;
    #1;
    check_eq("flush ready low", 64'(req_ready), 64'd0);
    next_cycle();
    flush = 1'b0;
    #1;
    check_eq("flush idle", {62'd0, busy, done}, 64'd0);
    check_eq("flush ready", 64'(req_ready), 64'd1);
    check_eq("flush hilo kept", {hi_rdata, lo_rdata}, {32'd0, 32'h8000_0000});
    run_op(MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, MulLat, "multu 2*3");

    // MTHI in idle: forwarded in its cycle, registered afterwards
    hi_write = 1'b1;
    hi_data  = 32'h1234;
    #1;
    check_eq("mthi fwd", 64'(hi_rdata), 64'h1234);
    next_cycle();
    hi_write = 1'b0;
    #1;
    check_eq("mthi reg", {hi_rdata, lo_rdata}, {32'h1234, 32'd6});

    // MTLO in COMMIT of MULTU 2*3: LO from write-back, HI still commits
    issue(MD_MULTU, 32'd2, 32'd3, "mtlo commit");
    wait_done(n);
    check_eq("mtlo latency", 64'(n), 64'(MulLat));
    lo_write = 1'b1;
    lo_data  = 32'hAA;
    #1;
    check_eq("mtlo fwd", {hi_rdata, lo_rdata}, {32'd0, 32'hAA});
    next_cycle();
    lo_write = 1'b0;
    #1;
    check_eq("mtlo reg", {hi_rdata, lo_rdata}, {32'd0, 32'hAA});

    // Reset in cycle T0+20 of a divide
    issue(MD_DIVU, 32'd77, 32'd5, "reset mid");
    repeat (19) next_cycle();
    resetn = 1'b0;
    next_cycle();
    check_eq("rst mid idle", {62'd0, busy, done}, 64'd0);
    check_eq("rst mid hilo", {hi_rdata, lo_rdata}, 64'd0);
    check_eq("rst mid ready", 64'(req_ready), 64'd1);
    resetn = 1'b1;
    next_cycle();
    run_op(MD_MULT, 32'd4, 32'd5, 32'd0, 32'd20, MulLat, "mult 4*5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
